// File: rtl/seg_scan_pkg.sv
// Shared types for the multiplexed seven-segment scan controller.
// Holds the scan state encoding and the counter sizing helper.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // Wide enough to hold the larger of the two dwell counts.
    function automatic int cnt_width(input int div, input int guard);
        int m;
        m = (div > guard) ? div : guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to seven-segment decoder, active-high segments.
// Bit order of seg_o is {g,f,e,d,c,b,a}.
module seven_segment (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b0000000;
        unique case (hex_i)
            4'h0: seg_o = 7'b0111111;
            4'h1: seg_o = 7'b0000110;
            4'h2: seg_o = 7'b1011011;
            4'h3: seg_o = 7'b1001111;
            4'h4: seg_o = 7'b1100110;
            4'h5: seg_o = 7'b1101101;
            4'h6: seg_o = 7'b1111101;
            4'h7: seg_o = 7'b0000111;
            4'h8: seg_o = 7'b1111111;
            4'h9: seg_o = 7'b1101111;
            4'hA: seg_o = 7'b1110111;
            4'hB: seg_o = 7'b1111100;
            4'hC: seg_o = 7'b0111001;
            4'hD: seg_o = 7'b1011110;
            4'hE: seg_o = 7'b1111001;
            4'hF: seg_o = 7'b1110001;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of hex seven-segment digits,
// with double-buffered value, guard gaps and leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int          NUM_DIGITS  = 4,
    parameter int          REFRESH_DIV = 50000,
    parameter int          GUARD_CYC   = 8,
    parameter logic [6:0]  BLANK_PAT   = 7'b0000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = cnt_width(REFRESH_DIV, GUARD_CYC);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] nibs_t;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    nibs_t           active_q, active_d;
    nibs_t           pending_q, pending_d;
    logic            pend_vld_q, pend_vld_d;
    logic            boundary;

    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  fd_q, fd_d;

    logic [3:0] nib;
    logic [6:0] dec_seg;
    logic       blank;
    logic       hi_zero;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d  = ST_SHOW;
                    idx_d    = '0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A load landing on the boundary goes straight to the live buffer.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            if (load) begin
                active_d = value;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pending_d  = value;
            pend_vld_d = 1'b1;
        end
    end

    assign nib = active_q[idx_q];

    seven_segment u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        hi_zero = lz_en;
        blank   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (active_q[k] != 4'h0) hi_zero = 1'b0;
            if (IW'(k) == idx_q) blank = hi_zero;
        end
        if (idx_q == '0) blank = 1'b0;
    end

    always_comb begin
        seg_d = BLANK_PAT;
        dig_d = '0;
        fd_d  = 1'b0;
        if (state_q == ST_SHOW) begin
            dig_d = NUM_DIGITS'(1) << idx_q;
            seg_d = blank ? BLANK_PAT : dec_seg;
            fd_d  = (idx_q == '0) && (cnt_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= BLANK_PAT;
            dig_q      <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of NUM_DIGITS hex seven-segment digits that share one seven_segment decoder.
- Holds a double-buffered display value and walks the digits one at a time.
- Inserts an anti-ghosting guard gap between digits and can suppress leading zeros.
- Sits between the datapath that produces values and the board-level segment/digit pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles each digit is driven (>=2)
GUARD_CYC, 8, cycles with all digit selects off between digits (>=1)
BLANK_PAT, 7'b0000000, segment pattern driven when a digit is blanked or scanning is off

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  scan enable; 0 = display off
load  input  1  one-cycle strobe; capture value into pending buffer
value  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
lz_en  input  1  leading-zero suppression enable
seg  output  7  segment pattern, taken from seven_segment out or BLANK_PAT
dig_sel  output  NUM_DIGITS  one-hot active-high digit select; all-zero when idle or in guard
frame_done  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset forces state OFF, digit index 0, both counters 0, active and pending buffers 0, pending_valid 0.
  - Outputs during reset: seg=BLANK_PAT, dig_sel=0, frame_done=0.
  - Reset asserted mid-scan takes effect immediately, with no frame completion.
- States: OFF, SHOW, GUARD.
  - OFF: enable=1 -> SHOW with index 0 and count cleared.
  - SHOW: stays REFRESH_DIV cycles, then -> GUARD.
  - GUARD: stays GUARD_CYC cycles. Then index = index+1 and -> SHOW, or, if index = NUM_DIGITS-1, index wraps to 0 and -> SHOW (frame boundary).
  - Any state with enable=0 -> OFF next cycle; index and count cleared. Buffers are kept.
- Frame length = NUM_DIGITS*(REFRESH_DIV+GUARD_CYC) cycles.
- Outputs are registered with 1-cycle latency from state.
  - dig_sel[index]=1 only while the previous-cycle state was SHOW.
  - seg = decoder(active nibble[index]), or BLANK_PAT when blanked, OFF or GUARD.
- Leading-zero suppression: digit i > 0 is blanked when lz_en=1 and nibbles NUM_DIGITS-1..i of the active buffer are all 0. Digit 0 is never blanked, so value 0 shows a single "0".
- Load handshake:
  - load=1 copies value into pending and sets pending_valid.
  - A further load before the boundary overwrites pending (last wins).
- Frame boundary transfer:
  - At the GUARD->SHOW wrap, if pending_valid, active<=pending and pending_valid clears.
  - If load coincides with the boundary cycle, the incoming value bypasses pending and is written directly to active; pending_valid clears.
  - Leaving OFF counts as a frame boundary, so pending is applied before the first digit.
- Digits never change mid-frame: no tearing.
- frame_done: registered, high exactly one cycle, aligned with the first cycle dig_sel[0]=1 of each frame, including the first frame after enable.
- Counter width: $clog2(max(REFRESH_DIV,GUARD_CYC)+1). The counter is compared against DIV-1 and never wraps freely.

Decomposition:
- Package seg_scan_pkg:
  - state enum (OFF, SHOW, GUARD).
  - Localparam helper for counter width.
- Sub-module: the existing seven_segment decoder, instantiated once on the selected nibble; no other sub-modules.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1.
- Reset then enable=1, load value=16'h1234 -> dig_sel 0001/0010/0100/1000, each for 4 cycles, separated by 1 cycle of 0000. seg = decoder(4), (3), (2), (1). frame_done every 20 cycles.
- Load 16'hABCD mid-frame (during digit 1) -> remaining digits of the current frame still show 1234. The next frame shows D,C,B,A, with frame_done aligned to dig_sel=0001.
- Two loads (16'h1111, then 16'h2222) in one frame -> next frame shows 2222 only. Load 16'h5555 exactly on the boundary cycle -> the frame starting there shows 5555.
- lz_en=1, value 16'h0070 -> digits 3,2 seg=BLANK_PAT with dig_sel still pulsing; digit 1 = decoder(7); digit 0 = decoder(0). Value 16'h0000 -> only digit 0 shows "0".
- enable dropped during digit 2 -> next cycle the state is OFF; one cycle later outputs read dig_sel=0, seg=BLANK_PAT. Re-enable -> restarts at digit 0 with frame_done pulse.
- rst_n pulsed low mid-SHOW (asynchronous, between clock edges) -> outputs go to reset values immediately. After release with enable=1, the display shows 0000 until the next load.
